alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Front-end controller that sequences one 32-bit ALU (add/mul/div/nand, op-select s, clear input r, finished flag).
- Accepts one operation at a time over a valid/ready request channel and holds ALU operands/select stable for the whole operation.
- For multi-cycle ops (multiply, divide): issues the one-cycle clear pulse, waits for finished, captures the result.
- Returns result plus error flag over a valid/ready response channel; sits between the instruction-decode logic and the ALU.

Parameters:
DATA_W, 32, operand/result width (must match ALU width)
TIMEOUT_CYCLES, 64, maximum WAIT-state cycles before abort (used only with the optional feature)

Ports:
clk  input  1  system clock, all state on rising edge
r  input  1  reset; synchronous, active-high; one clock domain (clk); reset is synchronous and active-high
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request (high only in IDLE)
req_op  input  2  00 add, 01 mul, 10 div, 11 nand
req_x  input  DATA_W  operand x
req_y  input  DATA_W  operand y
alu_x  output  DATA_W  registered operand to ALU x
alu_y  output  DATA_W  registered operand to ALU y
alu_s  output  2  registered op select to ALU s
alu_clr  output  1  registered clear/start pulse to ALU r
alu_out  input  DATA_W  ALU result
alu_finished  input  1  ALU finished flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  captured result
rsp_err  output  1  1 = divide by zero or timeout; rsp_data = 0
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (r=1 at clk edge), any state: state=IDLE; alu_x=0, alu_y=0, alu_s=00, alu_clr=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - alu_clr is held high while r is high, so a mid-operation reset also clears the ALU.
  - alu_clr returns to 0 on the first clock after r deasserts.
- States: IDLE, EXEC, CLEAR, WAIT, DONE.
- IDLE: req_ready=1, alu_clr=0. On req_valid, latch req_x/req_y/req_op into alu_x/alu_y/alu_s, then:
  - op 00 or 11 -> EXEC;
  - op 01, or op 10 with req_y!=0 -> CLEAR;
  - op 10 with req_y==0 -> DONE with rsp_err=1, rsp_data=0, no ALU launch.
- EXEC (single-cycle ops): capture alu_out into rsp_data, rsp_err=0 -> DONE. Latency from accept edge to rsp_valid = 2 clk.
- CLEAR: alu_clr=1 for exactly one cycle -> WAIT.
- WAIT: alu_clr=0.
  - alu_finished is ignored in the first WAIT cycle; this guards against a stale finished flag.
  - From the second WAIT cycle, alu_finished=1 -> capture alu_out, rsp_err=0 -> DONE.
- DONE: rsp_valid=1; rsp_data/rsp_err held stable.
  - rsp_ready=1 -> IDLE; the next request can be accepted one cycle later. No IDLE/DONE overlap.
  - rsp_ready low: hold indefinitely.
- alu_x/alu_y/alu_s are never changed outside IDLE acceptance, so operands are stable for the whole operation.
- req_ready is 0 in all non-IDLE states; requests presented then are not consumed.
- Simultaneous r and req_valid: reset wins, request not accepted.
- Arithmetic is performed only by the ALU; the sequencer does no width extension (result is the DATA_W low word as the ALU presents it).

Optional Feature:
Macro ALU_SEQ_TIMEOUT_EN.
- Defined:
  - WAIT-state cycle counter (width $clog2(TIMEOUT_CYCLES+1)) cleared on entering WAIT.
  - If the counter reaches TIMEOUT_CYCLES without a qualified alu_finished: go to DONE with rsp_err=1, rsp_data=0, and pulse alu_clr for one cycle on that transition.
  - finished and timeout in the same cycle: finished wins.
- Not defined: no counter; WAIT waits indefinitely for alu_finished.

Test Plan:
- Reset then add: req_op=00, x=5, y=7, rsp_ready=1 -> rsp_valid exactly 2 clk after accept, rsp_data=12, rsp_err=0; add x=FFFFFFFF, y=2 -> rsp_data=1.
- Multiply: req_op=01, x=3, y=4 -> alu_clr high exactly one cycle, alu_x/alu_y/alu_s stable until DONE, rsp_data=12, rsp_err=0 after alu_finished; busy high throughout.
- Divide by zero: req_op=10, x=100, y=0 -> alu_clr never pulses, rsp_valid 1 clk after accept, rsp_err=1, rsp_data=0.
- Backpressure: nand x=F0F0F0F0, y=FFFF0000, rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data=0F0FFFFF stable, req_ready=0, second req_valid not accepted until one cycle after handshake.
- Reset mid-multiply: assert r in WAIT cycle 10 -> next edge IDLE, rsp_valid=0, alu_clr=1 while r high, then a fresh mul 6*7 returns 42.
- With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, alu_finished stubbed 0 -> DONE after 8 WAIT cycles, rsp_err=1, rsp_data=0, one alu_clr pulse; without the macro, still busy after 1000 cycles.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for a 32-bit add/mul/div/nand ALU: one request in flight, multi-cycle ops launched with a clear pulse.
// Optional WAIT-state abort counter is compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_x,
  input  logic [DATA_W-1:0] req_y,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [1:0]        alu_s,
  output logic              alu_clr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_finished,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_CLEAR,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] alu_x_q;
  logic [DATA_W-1:0] alu_y_q;
  logic [1:0]        alu_s_q;
  logic              alu_clr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              wait_first_q;
  logic              timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counter holds the number of WAIT cycles already completed, so this is the last permitted one.
  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (r) begin
      state_q      <= S_IDLE;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_s_q      <= 2'b00;
      alu_clr_q    <= 1'b1;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wait_first_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      alu_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            alu_x_q <= req_x;
            alu_y_q <= req_y;
            alu_s_q <= req_op;
            case (req_op)
              2'b00, 2'b11: state_q <= S_EXEC;
              2'b01: begin
                state_q   <= S_CLEAR;
                alu_clr_q <= 1'b1;
              end
              default: begin
                if (req_y == '0) begin
                  // Divide by zero never reaches the ALU.
                  state_q    <= S_DONE;
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                end else begin
                  state_q   <= S_CLEAR;
                  alu_clr_q <= 1'b1;
                end
              end
            endcase
          end
        end
        S_EXEC: begin
          rsp_data_q <= alu_out;
          rsp_err_q  <= 1'b0;
          state_q    <= S_DONE;
        end
        S_CLEAR: begin
          state_q      <= S_WAIT;
          wait_first_q <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          wait_first_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
          wait_cnt_q   <= wait_cnt_q + CNT_W'(1);
`endif
          // A finished flag seen in the first WAIT cycle may be left over from the previous op.
          if (!wait_first_q && alu_finished) begin
            rsp_data_q <= alu_out;
            rsp_err_q  <= 1'b0;
            state_q    <= S_DONE;
          end else if (timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            alu_clr_q  <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_s     = alu_s_q;
  assign alu_clr   = alu_clr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stub plus per-scenario tasks checked against an op-level reference model.
// Builds with or without ALU_SEQ_TIMEOUT_EN; with it the timeout is set to 8 cycles.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        r;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [1:0]  alu_s;
  logic        alu_clr;
  logic [31:0] alu_out;
  logic        alu_finished;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_op_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .r(r),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_clr(alu_clr),
    .alu_out(alu_out), .alu_finished(alu_finished),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stub: add/nand combinational; mul/div become valid alu_lat cycles after the clear pulse.
  int   alu_lat   = 1;
  int   alu_cnt   = 0;
  logic alu_run   = 1'b0;
  logic alu_stale = 1'b0;
  bit   stall_mode = 1'b0;
  bit   stale_mode = 1'b0;
  logic alu_done;

  always @(posedge clk) begin
    alu_stale <= alu_clr;
    if (alu_clr) begin
      alu_run <= 1'b1;
      alu_cnt <= alu_lat;
    end else if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
    end
  end

  assign alu_done     = alu_run && (alu_cnt == 0) && !alu_clr;
  assign alu_finished = stall_mode ? 1'b0 : (alu_done || (stale_mode && alu_stale));

  always_comb begin
    alu_out = 32'hDEADBEEF;
    case (alu_s)
      2'b00: alu_out = alu_x + alu_y;
      2'b01: if (alu_done) alu_out = alu_x * alu_y;
      2'b10: if (alu_done && alu_y != 0) alu_out = alu_x / alu_y;
      default: alu_out = ~(alu_x & alu_y);
    endcase
  end

  // Reference: result and accept-to-response latency (edges, accept edge counted) per operation.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                    input int lat, output logic [31:0] d, output logic e, output int l);
    e = 1'b0;
    case (op)
      2'b00: begin d = x + y; l = 2; end
      2'b01: begin d = x * y; l = lat + 3; end
      2'b10: begin
        if (y == 0) begin d = 0; e = 1'b1; l = 1; end
        else begin d = x / y; l = lat + 3; end
      end
      default: begin d = ~(x & y); l = 2; end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input int hold, input string nm);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_l;
    int          exp_clr;
    int          n;
    int          clr_n;
    bit          stable_ok;
    bit          held_ok;
    logic [31:0] d0;
    ref_model(op, x, y, lat, exp_d, exp_e, exp_l);
    exp_clr   = (op == 2'b01 || (op == 2'b10 && y != 0)) ? 1 : 0;
    alu_lat   = lat;
    rsp_ready = (hold == 0);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s_ready: req_ready=%b expected 1", nm, req_ready);
    end
    req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_x = $urandom; req_y = $urandom;
    tests++;
    if (alu_x !== x || alu_y !== y || alu_s !== op) begin
      fails++; $display("FAIL %s_latch: alu x=%h y=%h s=%b expected x=%h y=%h s=%b", nm, alu_x, alu_y, alu_s, x, y, op);
    end
    n = 1; clr_n = 0; stable_ok = 1'b1;
    while (rsp_valid !== 1'b1 && n < 300) begin
      if (busy !== 1'b1 || req_ready !== 1'b0 || alu_x !== x || alu_y !== y || alu_s !== op) stable_ok = 1'b0;
      if (alu_clr === 1'b1) clr_n++;
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n != exp_l) begin
      fails++; $display("FAIL %s_latency: %0d cycles expected %0d", nm, n, exp_l);
    end
    tests++;
    if (rsp_data !== exp_d || rsp_err !== exp_e) begin
      fails++; $display("FAIL %s_result: data=%h err=%b expected data=%h err=%b", nm, rsp_data, rsp_err, exp_d, exp_e);
    end
    tests++;
    if (clr_n != exp_clr || !stable_ok) begin
      fails++; $display("FAIL %s_control: clr_cycles=%0d stable=%b expected clr_cycles=%0d stable=1", nm, clr_n, stable_ok, exp_clr);
    end
    d0 = rsp_data; held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = ~op; req_x = ~x; req_y = $urandom;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0 || alu_x !== x || alu_s !== op) held_ok = 1'b0;
    end
    req_valid = 1'b0;
    if (hold > 0) begin
      tests++;
      if (!held_ok) begin
        fails++; $display("FAIL %s_hold: response or operands changed under backpressure, got data=%h expected %h", nm, rsp_data, d0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_release: rsp_valid=%b req_ready=%b busy=%b expected 0 1 0", nm, rsp_valid, req_ready, busy);
    end
    $display("[TB] %s op=%0d x=%h y=%h lat=%0d hold=%0d -> data=%h err=%b", nm, op, x, y, lat, hold, d0, exp_e);
  endtask

  task automatic test_reset();
    r = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_x = 32'h1; req_y = 32'h2; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (alu_x !== 0 || alu_y !== 0 || alu_s !== 2'b00) begin
      fails++; $display("FAIL reset_operands: x=%h y=%h s=%b expected 0 0 00", alu_x, alu_y, alu_s);
    end
    tests++;
    if (alu_clr !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL reset_state: clr=%b busy=%b rsp_valid=%b data=%h err=%b expected 1 0 0 0 0",
                        alu_clr, busy, rsp_valid, rsp_data, rsp_err);
    end
    req_valid = 1'b0; r = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (alu_clr !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release: clr=%b req_ready=%b expected 0 1", alu_clr, req_ready);
    end
  endtask

  task automatic test_add();
    run_op(2'b00, 32'd5, 32'd7, 1, 0, "add_5_7");
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 1, 0, "add_wrap");
  endtask

  task automatic test_mul();
    run_op(2'b01, 32'd3, 32'd4, 4, 0, "mul_3_4");
    run_op(2'b10, 32'd100, 32'd7, 2, 0, "div_100_7");
  endtask

  task automatic test_div_zero();
    run_op(2'b10, 32'd100, 32'd0, 1, 0, "div_zero");
  endtask

  task automatic test_backpressure();
    run_op(2'b11, 32'hF0F0F0F0, 32'hFFFF0000, 1, 10, "nand_bp");
  endtask

  task automatic test_stale_finished();
    stale_mode = 1'b1;
    run_op(2'b01, 32'd9, 32'd11, 3, 0, "mul_stale");
    run_op(2'b10, 32'd1000, 32'd9, 1, 0, "div_stale");
    stale_mode = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int rst_at;
    rst_at = (TO > 12) ? 10 : TO - 3;
    alu_lat = 500;
    req_op = 2'b01; req_x = 32'd6; req_y = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    repeat (rst_at - 1) begin
      @(posedge clk); #1;
    end
    tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_inflight: busy=%b rsp_valid=%b expected 1 0", busy, rsp_valid);
    end
    r = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_clr !== 1'b1) begin
      fails++; $display("FAIL midrst_abort: busy=%b rsp_valid=%b clr=%b expected 0 0 1", busy, rsp_valid, alu_clr);
    end
    @(posedge clk); #1;
    r = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (alu_clr !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_release: clr=%b req_ready=%b expected 0 1", alu_clr, req_ready);
    end
    run_op(2'b01, 32'd6, 32'd7, 2, 0, "mul_after_reset");
  endtask

  task automatic test_random_back_to_back();
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      x  = $urandom;
      y  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      stale_mode = ($urandom_range(0, 3) == 0);
      run_op(op, x, y, $urandom_range(1, 5), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, "rand");
    end
    stale_mode = 1'b0;
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int clr_n;
    stall_mode = 1'b1; alu_lat = 1; rsp_ready = 1'b1;
    req_op = 2'b01; req_x = 32'd12; req_y = 32'd13; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; clr_n = 0;
    while (rsp_valid !== 1'b1 && n < 500) begin
      if (alu_clr === 1'b1) clr_n++;
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n != TO + 2) begin
      fails++; $display("FAIL timeout_latency: %0d cycles expected %0d", n, TO + 2);
    end
    tests++;
    if (rsp_err !== 1'b1 || rsp_data !== 0) begin
      fails++; $display("FAIL timeout_result: data=%h err=%b expected 0 1", rsp_data, rsp_err);
    end
    tests++;
    if (alu_clr !== 1'b1 || clr_n != 1) begin
      fails++; $display("FAIL timeout_clr: clr=%b launch_clr_cycles=%0d expected 1 1", alu_clr, clr_n);
    end
    @(posedge clk); #1;
    tests++;
    if (alu_clr !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL timeout_after: clr=%b rsp_valid=%b expected 0 0", alu_clr, rsp_valid);
    end
    $display("[TB] timeout mul -> err after %0d cycles", n);
    stall_mode = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    stall_mode = 1'b1; alu_lat = 1; rsp_ready = 1'b1;
    req_op = 2'b01; req_x = 32'd12; req_y = 32'd13; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL no_timeout: busy=%b rsp_valid=%b expected still busy after 1000 cycles", busy, rsp_valid);
    end
    $display("[TB] stalled mul still busy=%b after 1000 cycles", busy);
    r = 1'b1;
    @(posedge clk); #1;
    r = 1'b0; stall_mode = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    r = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_x = '0; req_y = '0; rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_backpressure();
    test_stale_finished();
    test_reset_mid_mul();
    test_random_back_to_back();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    run_op(2'b00, 32'd1, 32'd1, 1, 0, "add_final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
